// File: rtl/dom_sbox_seq_if.sv
// Handshake bundle between the round controller / PRNG side (master) and the
// DOM S-box stage sequencer (slave).
interface dom_sbox_seq_if #(
    parameter int NSTAGE = 4,
    parameter int R_W    = 6
);
    logic              in_valid;
    logic              in_ready;
    logic              load_en;
    logic [R_W-1:0]    rnd_in;
    logic              rnd_valid;
    logic              rnd_ready;
    logic [NSTAGE-1:0] stage_en;
    logic [R_W-1:0]    r_out;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic [15:0]       starve_cnt;

    modport master (
        output in_valid, rnd_in, rnd_valid, out_ready,
        input  in_ready, load_en, rnd_ready, stage_en, r_out, out_valid, busy, starve_cnt
    );

    modport slave (
        input  in_valid, rnd_in, rnd_valid, out_ready,
        output in_ready, load_en, rnd_ready, stage_en, r_out, out_valid, busy, starve_cnt
    );
endinterface

// File: rtl/dom_sbox_seq.sv
// Serial sequencer for a 2-share DOM S-box: steps NSTAGE register stages, each
// firing only on a freshly handshaked PRNG word that is routed to its gadgets.
module dom_sbox_seq #(
    parameter int NSTAGE = 4,
    parameter int R_W    = 6
) (
    input  logic           clk,
    input  logic           rst,
    dom_sbox_seq_if.slave  bus
);
    localparam int IDX_W = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSTAGE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_next;
    logic [15:0]      r_starve_cnt;
    logic [15:0]      w_starve_next;
    logic             w_accept;
    logic             w_fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_starve_cnt <= '0;
        end else begin
            r_state      <= w_state_next;
            r_idx        <= w_idx_next;
            r_starve_cnt <= w_starve_next;
        end
    end

    // rst also gates the strobes so nothing leaks out while reset is held.
    always_comb begin
        w_state_next  = r_state;
        w_idx_next    = r_idx;
        w_starve_next = r_starve_cnt;
        w_accept      = 1'b0;
        w_fire        = 1'b0;
        case (r_state)
            IDLE: begin
                w_accept = bus.in_valid && !rst;
                if (w_accept) begin
                    w_idx_next   = '0;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                w_fire = bus.rnd_valid && !rst;
                if (w_fire) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_next = DONE;
                    end else begin
                        w_idx_next = r_idx + 1'b1;
                    end
                end else if (r_starve_cnt != 16'hFFFF) begin
                    w_starve_next = r_starve_cnt + 16'd1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign bus.in_ready   = !rst && (r_state == IDLE);
    assign bus.load_en    = w_accept;
    assign bus.rnd_ready  = !rst && (r_state == RUN);
    assign bus.out_valid  = !rst && (r_state == DONE);
    assign bus.busy       = !rst && (r_state != IDLE);
    assign bus.starve_cnt = r_starve_cnt;

    generate
        for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_stage_en
            assign bus.stage_en[gi] = w_fire && (r_idx == IDX_W'(gi));
        end
        // Randomness is forced to zero on non-firing cycles so no stale word reaches a gadget.
        for (genvar gi = 0; gi < R_W; gi++) begin : g_r_out
            assign bus.r_out[gi] = w_fire && bus.rnd_in[gi];
        end
    endgenerate

    a_stage_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(bus.stage_en));
    a_gated_rand: assert property (@(posedge clk) disable iff (rst)
        !w_fire |-> (bus.r_out == '0 && bus.stage_en == '0));
    a_ready_in_run: assert property (@(posedge clk) disable iff (rst)
        bus.rnd_ready |-> (r_state == RUN));
endmodule

// File: tb/tb_dom_sbox_seq.sv
// Scenario bench for dom_sbox_seq: expected stage fires are queued when a
// fresh word is driven and popped when that cycle's outputs are sampled.
module tb_dom_sbox_seq;
    localparam int NSTAGE = 4;
    localparam int R_W    = 6;
    localparam int EW     = NSTAGE + R_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dom_sbox_seq_if #(.NSTAGE(NSTAGE), .R_W(R_W)) bus ();
    dom_sbox_seq #(.NSTAGE(NSTAGE), .R_W(R_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [EW-1:0] exp_q [$];
    int n_tests    = 0;
    int n_fail     = 0;
    int hs_cnt     = 0;
    int exp_starve = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic rv, input logic [R_W-1:0] ri, input logic orr);
        bus.in_valid  = iv;
        bus.rnd_valid = rv;
        bus.rnd_in    = ri;
        bus.out_ready = orr;
    endtask

    task automatic expect_fire(input int k, input logic [R_W-1:0] w);
        logic [NSTAGE-1:0] se;
        se    = '0;
        se[k] = 1'b1;
        exp_q.push_back({se, w});
    endtask

    task automatic test_reset();
        logic [14:0] outs;
        rst = 1'b1;
        drive(1'b1, 1'b1, '1, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            outs = {bus.in_ready, bus.load_en, bus.rnd_ready, bus.stage_en, bus.r_out, bus.out_valid, bus.busy};
            n_tests++;
            if (outs !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs c=%0d: outputs=%b, required all 0", c, outs);
            end
            tick();
        end
        rst = 1'b0;
        drive(1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready);
        end
        n_tests++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b, required 0", bus.busy);
        end
        n_tests++;
        if (bus.starve_cnt !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_starve: got %h, required 0000", bus.starve_cnt);
        end
        $display("[TB] reset: outputs held low, released to IDLE");
        tick();
    endtask

    task automatic test_nominal();
        logic [R_W-1:0] words [4];
        logic [EW-1:0]  e;
        logic           fire_now;
        words = '{6'h15, 6'h2A, 6'h3F, 6'h01};
        for (int c = 0; c < 7; c++) begin
            fire_now = (c >= 1 && c <= 4);
            drive(c == 0, 1'b1, fire_now ? words[c-1] : 6'h2D, 1'b1);
            if (fire_now) expect_fire(c - 1, words[c-1]);
            @(negedge clk);
            e = '0;
            if (fire_now) e = exp_q.pop_front();
            n_tests++;
            if ({bus.stage_en, bus.r_out} !== e) begin
                n_fail++;
                $display("FAIL nominal_stage c=%0d: stage_en/r_out=%b/%h, required %b/%h",
                         c, bus.stage_en, bus.r_out, e[EW-1:R_W], e[R_W-1:0]);
            end
            if (bus.rnd_ready && bus.rnd_valid) hs_cnt++;
            n_tests++;
            if (bus.load_en !== (c == 0) || bus.out_valid !== (c == 5) || bus.in_ready !== (c == 0 || c == 6)) begin
                n_fail++;
                $display("FAIL nominal_ctrl c=%0d: load_en/out_valid/in_ready=%b%b%b, required %b%b%b",
                         c, bus.load_en, bus.out_valid, bus.in_ready, c == 0, c == 5, c == 0 || c == 6);
            end
            tick();
        end
        drive(1'b0, 1'b0, '0, 1'b0);
        n_tests++;
        if (bus.starve_cnt !== 16'(exp_starve)) begin
            n_fail++;
            $display("FAIL nominal_starve: got %h, required %h", bus.starve_cnt, 16'(exp_starve));
        end
        $display("[TB] nominal: 4 stages fired, out_valid at cycle 5");
    endtask

    task automatic test_starvation();
        logic [EW-1:0]  e;
        logic [R_W-1:0] w;
        logic           fire_now;
        logic           stall;
        int             k;
        int             hs0;
        k   = 0;
        hs0 = hs_cnt;
        for (int c = 0; c < 10; c++) begin
            stall    = (c >= 3 && c <= 5);
            fire_now = (c >= 1 && c <= 7 && !stall);
            w        = R_W'($urandom) | R_W'(1);
            drive(c == 0, fire_now, w, 1'b1);
            if (fire_now) begin
                expect_fire(k, w);
                k++;
            end
            @(negedge clk);
            e = '0;
            if (fire_now) e = exp_q.pop_front();
            n_tests++;
            if ({bus.stage_en, bus.r_out} !== e) begin
                n_fail++;
                $display("FAIL starve_stage c=%0d: stage_en/r_out=%b/%h, required %b/%h",
                         c, bus.stage_en, bus.r_out, e[EW-1:R_W], e[R_W-1:0]);
            end
            if (bus.rnd_ready && bus.rnd_valid) hs_cnt++;
            n_tests++;
            if (bus.out_valid !== (c == 8)) begin
                n_fail++;
                $display("FAIL starve_out_valid c=%0d: got %b, required %b", c, bus.out_valid, c == 8);
            end
            if (stall) exp_starve++;
            tick();
        end
        drive(1'b0, 1'b0, '0, 1'b0);
        n_tests++;
        if (bus.starve_cnt !== 16'(exp_starve) || exp_starve != 3) begin
            n_fail++;
            $display("FAIL starve_count: got %h, required 0003", bus.starve_cnt);
        end
        n_tests++;
        if (hs_cnt - hs0 != 4) begin
            n_fail++;
            $display("FAIL starve_handshakes: got %0d, required 4", hs_cnt - hs0);
        end
        $display("[TB] starvation: 3 stall cycles, out_valid at cycle 8");
    endtask

    task automatic test_backpressure();
        logic [EW-1:0]  e;
        logic [R_W-1:0] w;
        logic           fire_now;
        for (int c = 0; c < 12; c++) begin
            fire_now = (c >= 1 && c <= 4);
            w        = R_W'($urandom);
            drive(c <= 10, 1'b1, w, (c >= 1 && c <= 4) || c >= 10);
            if (fire_now) expect_fire(c - 1, w);
            @(negedge clk);
            e = '0;
            if (fire_now) e = exp_q.pop_front();
            n_tests++;
            if ({bus.stage_en, bus.r_out} !== e) begin
                n_fail++;
                $display("FAIL bp_stage c=%0d: stage_en/r_out=%b/%h, required %b/%h",
                         c, bus.stage_en, bus.r_out, e[EW-1:R_W], e[R_W-1:0]);
            end
            if (c >= 1 && c <= 4) begin
                n_tests++;
                if (bus.load_en !== 1'b0 || bus.out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_run_ignore c=%0d: load_en/out_valid=%b%b, required 00", c, bus.load_en, bus.out_valid);
                end
            end
            if (c >= 5 && c <= 10) begin
                n_tests++;
                if ({bus.out_valid, bus.in_ready, bus.rnd_ready, bus.load_en} !== 4'b1000) begin
                    n_fail++;
                    $display("FAIL bp_hold c=%0d: out_valid/in_ready/rnd_ready/load_en=%b%b%b%b, required 1000",
                             c, bus.out_valid, bus.in_ready, bus.rnd_ready, bus.load_en);
                end
            end
            if (c == 11) begin
                n_tests++;
                if ({bus.in_ready, bus.busy, bus.out_valid} !== 3'b100) begin
                    n_fail++;
                    $display("FAIL bp_release: in_ready/busy/out_valid=%b%b%b, required 100", bus.in_ready, bus.busy, bus.out_valid);
                end
            end
            tick();
        end
        drive(1'b0, 1'b0, '0, 1'b0);
        $display("[TB] backpressure: out_valid held 5 cycles, then IDLE");
    endtask

    task automatic test_reset_mid_run();
        logic [EW-1:0]  e;
        logic [R_W-1:0] w;
        logic           fire_now;
        logic [14:0]    outs;
        for (int c = 0; c < 11; c++) begin
            fire_now = (c == 1 || c == 2 || (c >= 5 && c <= 8));
            w        = R_W'($urandom);
            rst      = (c == 3);
            drive(c == 0 || c == 3 || c == 4, 1'b1, w, 1'b1);
            if (fire_now) expect_fire((c <= 2) ? c - 1 : c - 5, w);
            @(negedge clk);
            e = '0;
            if (fire_now) e = exp_q.pop_front();
            n_tests++;
            if ({bus.stage_en, bus.r_out} !== e) begin
                n_fail++;
                $display("FAIL rstrun_stage c=%0d: stage_en/r_out=%b/%h, required %b/%h",
                         c, bus.stage_en, bus.r_out, e[EW-1:R_W], e[R_W-1:0]);
            end
            if (c == 3) begin
                outs = {bus.in_ready, bus.load_en, bus.rnd_ready, bus.stage_en, bus.r_out, bus.out_valid, bus.busy};
                n_tests++;
                if (outs !== '0) begin
                    n_fail++;
                    $display("FAIL rstrun_outputs: outputs=%b, required all 0", outs);
                end
                exp_starve = 0;
            end
            if (c == 4) begin
                n_tests++;
                if (bus.in_ready !== 1'b1 || bus.load_en !== 1'b1 || bus.starve_cnt !== 16'(exp_starve)) begin
                    n_fail++;
                    $display("FAIL rstrun_restart: in_ready/load_en=%b%b starve=%h, required 11 starve=%h",
                             bus.in_ready, bus.load_en, bus.starve_cnt, 16'(exp_starve));
                end
            end
            n_tests++;
            if (bus.out_valid !== (c == 9)) begin
                n_fail++;
                $display("FAIL rstrun_out_valid c=%0d: got %b, required %b", c, bus.out_valid, c == 9);
            end
            tick();
        end
        rst = 1'b0;
        drive(1'b0, 1'b0, '0, 1'b0);
        $display("[TB] reset mid-RUN: aborted, new evaluation restarted at stage 0");
    endtask

    task automatic test_back_to_back();
        logic [EW-1:0]  e;
        logic [R_W-1:0] w;
        logic           fire_now;
        int             ph;
        for (int c = 0; c < 19; c++) begin
            ph       = c % (NSTAGE + 2);
            fire_now = (c < 18) && (ph >= 1 && ph <= NSTAGE);
            w        = R_W'($urandom);
            drive(c < 18, 1'b1, w, 1'b1);
            if (fire_now) expect_fire(ph - 1, w);
            @(negedge clk);
            e = '0;
            if (fire_now) e = exp_q.pop_front();
            n_tests++;
            if ({bus.stage_en, bus.r_out} !== e) begin
                n_fail++;
                $display("FAIL b2b_stage c=%0d: stage_en/r_out=%b/%h, required %b/%h",
                         c, bus.stage_en, bus.r_out, e[EW-1:R_W], e[R_W-1:0]);
            end
            n_tests++;
            if (bus.load_en !== (c < 18 && ph == 0) || bus.out_valid !== (ph == NSTAGE + 1)) begin
                n_fail++;
                $display("FAIL b2b_ctrl c=%0d: load_en/out_valid=%b%b, required %b%b",
                         c, bus.load_en, bus.out_valid, c < 18 && ph == 0, ph == NSTAGE + 1);
            end
            tick();
        end
        drive(1'b0, 1'b0, '0, 1'b0);
        $display("[TB] back-to-back: 3 evaluations, one per %0d cycles", NSTAGE + 2);
    endtask

    task automatic test_saturation();
        logic [EW-1:0]  e;
        logic [R_W-1:0] w;
        logic [15:0]    req;
        drive(1'b1, 1'b0, '0, 1'b0);
        tick();
        for (int i = 0; i < 70000; i++) begin
            drive(1'b0, 1'b0, R_W'($urandom) | R_W'(1), 1'b0);
            @(negedge clk);
            n_tests++;
            if ({bus.stage_en, bus.r_out} !== '0 || bus.rnd_ready !== 1'b1) begin
                n_fail++;
                if (n_fail < 20)
                    $display("FAIL sat_gate i=%0d: stage_en/r_out/rnd_ready=%b/%h/%b, required 0/00/1",
                             i, bus.stage_en, bus.r_out, bus.rnd_ready);
            end
            if (i % 8192 == 0 || (exp_starve >= 65533 && exp_starve <= 65537)) begin
                req = (exp_starve > 65535) ? 16'hFFFF : 16'(exp_starve);
                n_tests++;
                if (bus.starve_cnt !== req) begin
                    n_fail++;
                    $display("FAIL sat_count i=%0d: got %h, required %h", i, bus.starve_cnt, req);
                end
            end
            exp_starve++;
            tick();
        end
        for (int c = 0; c < 6; c++) begin
            w = R_W'($urandom);
            drive(1'b0, c < NSTAGE, w, 1'b1);
            if (c < NSTAGE) expect_fire(c, w);
            @(negedge clk);
            e = '0;
            if (c < NSTAGE) e = exp_q.pop_front();
            n_tests++;
            if ({bus.stage_en, bus.r_out} !== e) begin
                n_fail++;
                $display("FAIL sat_stage c=%0d: stage_en/r_out=%b/%h, required %b/%h",
                         c, bus.stage_en, bus.r_out, e[EW-1:R_W], e[R_W-1:0]);
            end
            n_tests++;
            if (bus.out_valid !== (c == NSTAGE)) begin
                n_fail++;
                $display("FAIL sat_out_valid c=%0d: got %b, required %b", c, bus.out_valid, c == NSTAGE);
            end
            tick();
        end
        drive(1'b0, 1'b0, '0, 1'b0);
        n_tests++;
        if (bus.starve_cnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL sat_final: got %h, required ffff", bus.starve_cnt);
        end
        $display("[TB] saturation: 70000 stall cycles, starve_cnt=%h", bus.starve_cnt);
    endtask

    initial begin
        drive(1'b0, 1'b0, '0, 1'b0);
        test_reset();
        test_nominal();
        test_starvation();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        test_saturation();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dom_sbox_seq.md
# dom_sbox_seq

Serial sequencer for a masked (first-order DOM, 2-share) S-box datapath built from chains of DOM-independent AND gadgets, where each gadget stage registers its cross-domain terms once per evaluation. The block accepts one masked S-box evaluation at a time and steps the datapath through `NSTAGE` register stages. For each stage it fetches exactly one fresh randomness word from an external PRNG over a valid/ready handshake and fires that stage only when fresh randomness is present. It sits between the round controller (input/output handshakes) and the S-box share datapath plus the PRNG.

## Interface
- `NSTAGE`, 4: number of DOM register stages in the S-box datapath; must be ≥ 1.
- `R_W`, 6: fresh-randomness bits consumed by one stage, i.e. one `r` bit per DOM AND gadget in that stage.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `in_valid` input 1: controller presents a new masked S-box input.
- `in_ready` output 1: sequencer can accept an input.
- `load_en` output 1: one-cycle pulse; datapath captures input shares on this edge.
- `rnd_in` input `R_W`: fresh randomness word from the PRNG.
- `rnd_valid` input 1: `rnd_in` is fresh.
- `rnd_ready` output 1: sequencer consumes `rnd_in` this cycle.
- `stage_en` output `NSTAGE`: one-hot clock enable for the DOM stage registers.
- `r_out` output `R_W`: randomness routed to the firing stage's gadgets.
- `out_valid` output 1: S-box output shares are final.
- `out_ready` input 1: controller takes the result.
- `busy` output 1: state ≠ IDLE.
- `starve_cnt` output 16: cycles spent waiting for randomness, saturating.

## Operation
- FSM states: IDLE, RUN, DONE. Stage index `idx` is clog2(`NSTAGE`) bits wide (1 bit when `NSTAGE`=1).
- IDLE:
  - `in_ready`=1.
  - `in_valid`&`in_ready`: `load_en`=1 this cycle; `idx`←0; next state RUN.
- RUN:
  - `rnd_ready`=1. `fire` = `rnd_valid` (combinational).
  - On `fire`: `stage_en` = 1<<`idx` and `r_out` = `rnd_in` in the same cycle; the consumed word is never reused.
  - On `fire` with `idx`=`NSTAGE`-1: next state DONE. Otherwise `idx`←`idx`+1.
  - No `fire`: `stage_en`=0, `r_out`=0 (gated to zero, never stale randomness); `starve_cnt`←min(`starve_cnt`+1, 16'hFFFF).
- DONE:
  - `out_valid`=1, held until `out_ready`.
  - `out_valid`&`out_ready`: next state IDLE.
  - `in_ready` stays 0 in DONE; there is no same-cycle handoff to a new input.
- Outside RUN: `rnd_ready`=0, `stage_en`=0, `r_out`=0. `rnd_valid` is ignored and no word is consumed.
- `in_valid` in RUN or DONE is ignored. `out_ready` outside DONE is ignored.
- `starve_cnt` counts only in RUN and is never cleared except by `rst`.

## Timing
- While `rst`=1, every output is held at 0 (`in_ready`, `load_en`, `rnd_ready`, `stage_en`, `r_out`, `out_valid`, `busy`). On the edge with `rst`=1: state←IDLE, `idx`←0, `starve_cnt`←0.
- The first cycle after `rst` falls has `in_ready`=1.
- Reset mid-RUN or mid-DONE aborts the evaluation:
  - no further `stage_en` pulses;
  - `out_valid` drops in the cycle `rst` is high;
  - any partial datapath state is discarded by the controller.
- `load_en`, `stage_en`, `rnd_ready` and `r_out` are combinational from state and inputs. `out_valid`, `in_ready` and `busy` are decoded from state only.
- Latency with `rnd_valid` held at 1:
  - accept at cycle 0;
  - stage k fires in cycle k+1;
  - `out_valid` is first high in cycle `NSTAGE`+1.
- Throughput with `out_ready` held at 1: one evaluation per `NSTAGE`+2 cycles.
- Each randomness stall cycle adds exactly one cycle of latency.
- Exactly `NSTAGE` words are consumed per evaluation, and exactly one `stage_en` bit is high per fire.

## Test plan
- Reset with all inputs driven high for 3 cycles: all outputs stay 0; after release, `in_ready`=1, `busy`=0, `starve_cnt`=0.
- Nominal run, `NSTAGE`=4, `rnd_valid`=1, `rnd_in`=6'h15,6'h2A,6'h3F,6'h01, `out_ready`=1:
  - accept at cycle 0 with `load_en`=1;
  - `stage_en`=0001,0010,0100,1000 in cycles 1–4, with matching `r_out`;
  - `out_valid`=1 in cycle 5; `in_ready`=1 in cycle 6.
- Starvation: `rnd_valid` low for 3 cycles after the second fire:
  - `stage_en`=0 and `r_out`=0 in those cycles;
  - `starve_cnt`=3;
  - `out_valid` first high in cycle 8;
  - total `rnd_ready`&`rnd_valid` handshakes = 4.
- Backpressure: `out_ready`=0 for 5 cycles in DONE:
  - `out_valid` held;
  - `in_valid`=1 is not accepted, `in_ready`=0;
  - `rnd_ready`=0;
  - after `out_ready`=1 the state returns to IDLE.
- Reset mid-RUN after 2 fires: the next cycle has all outputs 0; the cycle after has `in_ready`=1; a new evaluation fires stage 0 first.
- Saturation: `rnd_valid` held 0 in RUN for 70000 cycles → `starve_cnt`=16'hFFFF and stays there.
